// File: rtl/bram_frame_pkg.sv
// Shared types and helpers for the frame BRAM agents.
// Address width is derived from the frame geometry. The FSM state enum lives here.
package bram_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // A degenerate 1-word frame still needs a 1-bit address bus.
  function automatic int frame_addr_w(input int w, input int h);
    if (w * h > 1) return $clog2(w * h);
    else return 1;
  endfunction

endpackage

// File: rtl/bram_reader_2out_buf.sv
// Purpose: 2-entry word FIFO with per-entry a/b taken flags. Latency: 0, a word arriving from BRAM is presented the same cycle.
// Backpressure: an entry stays at the head until both streams have taken it. The caller must never push into a full FIFO.
module bram_reader_2out_buf #(
  parameter int pw = 21
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [pw-1:0] i_push_dat,
  input  logic          i_a_rdy,
  input  logic          i_b_rdy,
  output logic          o_a_vld,
  output logic          o_b_vld,
  output logic [pw-1:0] o_head_dat,
  output logic          o_pop,
  output logic [1:0]    o_cnt
);

  logic [pw-1:0] r_dat [2];
  logic [1:0]    r_a_tk;
  logic [1:0]    r_b_tk;
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic [1:0]    r_cnt;

  logic w_empty;
  logic w_head_vld;
  logic w_head_a_tk;
  logic w_head_b_tk;
  logic w_a_hs;
  logic w_b_hs;
  logic w_wr;

  // When empty, the word arriving this cycle is the head (flow-through).
  always_comb begin
    w_empty     = (r_cnt == 2'd0);
    w_head_vld  = !w_empty || i_push;
    w_head_a_tk = !w_empty && r_a_tk[r_rd_ptr];
    w_head_b_tk = !w_empty && r_b_tk[r_rd_ptr];
    o_a_vld     = w_head_vld && !w_head_a_tk;
    o_b_vld     = w_head_vld && !w_head_b_tk;
    w_a_hs      = o_a_vld && i_a_rdy;
    w_b_hs      = o_b_vld && i_b_rdy;
    o_pop       = w_head_vld && (w_head_a_tk || w_a_hs) && (w_head_b_tk || w_b_hs);
    w_wr        = i_push && !(w_empty && o_pop);
    o_head_dat  = (w_empty && i_push) ? i_push_dat : r_dat[r_rd_ptr];
    o_cnt       = r_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dat[0] <= '0;
      r_dat[1] <= '0;
      r_a_tk   <= '0;
      r_b_tk   <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (!w_empty) begin
        if (o_pop) begin
          r_a_tk[r_rd_ptr] <= 1'b0;
          r_b_tk[r_rd_ptr] <= 1'b0;
          r_rd_ptr         <= ~r_rd_ptr;
        end else begin
          if (w_a_hs) r_a_tk[r_rd_ptr] <= 1'b1;
          if (w_b_hs) r_b_tk[r_rd_ptr] <= 1'b1;
        end
      end
      // A flow-through word that was half taken keeps its flag when stored.
      if (w_wr) begin
        r_dat[r_wr_ptr]  <= i_push_dat;
        r_a_tk[r_wr_ptr] <= w_empty && w_a_hs;
        r_b_tk[r_wr_ptr] <= w_empty && w_b_hs;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, o_pop};
    end
  end

endmodule

// File: rtl/bram_reader_2out.sv
// Purpose: streams one frame from a double-buffered BRAM and splits each word {a, b} into two valid/ready streams.
// Latency: start at T gives rd_address 0 at T+1 and valid at T+2. Backpressure: reads stall while FIFO plus in-flight reads reach 2. BRAM_READER_2OUT_LAST_EN adds a_last/b_last.
module bram_reader_2out
  import bram_frame_pkg::*;
#(
  parameter int width   = 120,
  parameter int height  = 240,
  parameter int a_width = 13,
  parameter int b_width = 8
) (
`ifdef BRAM_READER_2OUT_LAST_EN
  output logic                                  a_last,
  output logic                                  b_last,
`endif
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  bram_index_in,
  output logic                                  idle,
  output logic                                  rd_bram_index,
  output logic [frame_addr_w(width, height)-1:0] rd_address,
  input  logic [a_width+b_width-1:0]            rd_data,
  output logic [a_width-1:0]                    a_data,
  output logic                                  a_valid,
  input  logic                                  a_ready,
  output logic [b_width-1:0]                    b_data,
  output logic                                  b_valid,
  input  logic                                  b_ready
);

  localparam int frame_size = width * height;
  localparam int addr_w     = frame_addr_w(width, height);
  localparam int data_width = a_width + b_width;
`ifdef BRAM_READER_2OUT_LAST_EN
  localparam int pw = data_width + 1;
`else
  localparam int pw = data_width;
`endif
  localparam logic [addr_w-1:0] last_addr = addr_w'(frame_size - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_rd_bram_index;
  logic [addr_w-1:0] r_addr;
  logic              r_inflight;
  logic              w_issue;
  logic              w_last_addr;
  logic              w_pop;
  logic              w_drain_done;
  logic [1:0]        w_cnt;
  logic [2:0]        w_pending;
  logic [pw-1:0]     w_push_dat;
  logic [pw-1:0]     w_head_dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_issue && w_last_addr) w_next = DRAIN;
      DRAIN:   if (w_drain_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Credit counts stored words plus the read whose data lands next cycle.
  always_comb begin
    w_pending    = {1'b0, w_cnt} + {2'b00, r_inflight};
    w_last_addr  = (r_addr == last_addr);
    idle         = (r_state == IDLE);
    w_issue      = (r_state == RUN) && (w_pending < 3'd2);
    w_drain_done = (r_state == DRAIN) && w_pop && (w_pending == 3'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_bram_index <= 1'b0;
      r_addr          <= '0;
      r_inflight      <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (idle && start) begin
        r_rd_bram_index <= bram_index_in;
        r_addr          <= '0;
      end else if (w_issue && !w_last_addr) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

`ifdef BRAM_READER_2OUT_LAST_EN
  logic r_inflight_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_inflight_last <= 1'b0;
    else       r_inflight_last <= w_issue && w_last_addr;
  end

  assign w_push_dat = {r_inflight_last, rd_data};
  assign a_last     = a_valid && w_head_dat[pw-1];
  assign b_last     = b_valid && w_head_dat[pw-1];
`else
  assign w_push_dat = rd_data;
`endif

  bram_reader_2out_buf #(
    .pw(pw)
  ) u_buf (
    .clk       (clk),
    .rst       (reset),
    .i_push    (r_inflight),
    .i_push_dat(w_push_dat),
    .i_a_rdy   (a_ready),
    .i_b_rdy   (b_ready),
    .o_a_vld   (a_valid),
    .o_b_vld   (b_valid),
    .o_head_dat(w_head_dat),
    .o_pop     (w_pop),
    .o_cnt     (w_cnt)
  );

  assign rd_bram_index = r_rd_bram_index;
  assign rd_address    = r_addr;
  assign a_data        = w_head_dat[data_width-1:b_width];
  assign b_data        = w_head_dat[b_width-1:0];

endmodule

// File: tb/tb_bram_reader_2out.sv
// Directed bench for bram_reader_2out on a 4x2 frame with a scoreboard per output stream.
module tb_bram_reader_2out;

  localparam int W      = 4;
  localparam int H      = 2;
  localparam int A_W    = 13;
  localparam int B_W    = 8;
  localparam int D_W    = A_W + B_W;
  localparam int N      = W * H;
  localparam int ADDR_W = 3;
`ifdef BRAM_READER_2OUT_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              bram_index_in = 1'b0;
  logic              a_ready = 1'b1;
  logic              b_ready = 1'b1;
  logic              idle;
  logic              rd_bram_index;
  logic [ADDR_W-1:0] rd_address;
  logic [D_W-1:0]    rd_data;
  logic [A_W-1:0]    a_data;
  logic [B_W-1:0]    b_data;
  logic              a_valid;
  logic              b_valid;
  logic              a_last_obs;
  logic              b_last_obs;

  logic [D_W-1:0] mem [N];
  logic [A_W:0]   qa [$];
  logic [B_W:0]   qb [$];
  logic [A_W:0]   exp_a;
  logic [B_W:0]   exp_b;

  int n_checks = 0;
  int n_errors = 0;
  int n_a      = 0;
  int n_b      = 0;
  int n_vcyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_address];

`ifdef BRAM_READER_2OUT_LAST_EN
  logic a_last;
  logic b_last;
  assign a_last_obs = a_last;
  assign b_last_obs = b_last;
`else
  assign a_last_obs = 1'b0;
  assign b_last_obs = 1'b0;
`endif

  bram_reader_2out #(
    .width  (W),
    .height (H),
    .a_width(A_W),
    .b_width(B_W)
  ) dut (
`ifdef BRAM_READER_2OUT_LAST_EN
    .a_last       (a_last),
    .b_last       (b_last),
`endif
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bram_index_in(bram_index_in),
    .idle         (idle),
    .rd_bram_index(rd_bram_index),
    .rd_address   (rd_address),
    .rd_data      (rd_data),
    .a_data       (a_data),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .b_data       (b_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready)
  );

  // Handshakes are sampled on the falling edge, halfway between input changes and the accepting edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_valid || b_valid) n_vcyc++;
      if (a_valid && a_ready) begin
        n_a++;
        n_checks++;
        if (qa.size() == 0) begin
          n_errors++;
          $error("FAIL a_extra_word obs=%0h exp=none", a_data);
        end else begin
          exp_a = qa.pop_front();
          assert ({a_last_obs, a_data} === exp_a) else begin
            n_errors++;
            $error("FAIL a_word obs=%0h exp=%0h", {a_last_obs, a_data}, exp_a);
          end
        end
      end
      if (b_valid && b_ready) begin
        n_b++;
        n_checks++;
        if (qb.size() == 0) begin
          n_errors++;
          $error("FAIL b_extra_word obs=%0h exp=none", b_data);
        end else begin
          exp_b = qb.pop_front();
          assert ({b_last_obs, b_data} === exp_b) else begin
            n_errors++;
            $error("FAIL b_word obs=%0h exp=%0h", {b_last_obs, b_data}, exp_b);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Drives one start cycle and queues the whole frame on both scoreboards.
  task automatic start_frame(input logic idx);
    for (int i = 0; i < N; i++) begin
      qa.push_back({LAST_EN && (i == N - 1), 13'(i + 1)});
      qb.push_back({LAST_EN && (i == N - 1), 8'(8'h10 + i)});
    end
    start = 1'b1;
    bram_index_in = idx;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    while (idle !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(tag, {31'd0, idle}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idle"}, {31'd0, idle}, 32'd1);
    check({tag, "_index"}, {31'd0, rd_bram_index}, 32'd0);
    check({tag, "_addr"}, {29'd0, rd_address}, 32'd0);
    check({tag, "_avalid"}, {31'd0, a_valid}, 32'd0);
    check({tag, "_bvalid"}, {31'd0, b_valid}, 32'd0);
    check({tag, "_adata"}, {19'd0, a_data}, 32'd0);
    check({tag, "_bdata"}, {24'd0, b_data}, 32'd0);
    check({tag, "_alast"}, {31'd0, a_last_obs}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int base_a;
    int base_b;
    int vbase;
    logic [ADDR_W-1:0] stall_addr;

    for (int i = 0; i < N; i++) mem[i] = {13'(i + 1), 8'(8'h10 + i)};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("post_rst");

    // Full-rate frame: valid continuous from T+2, idle after the 8th consume.
    base_a = n_a;
    start_frame(1'b0);
    check("t1_idle_drop", {31'd0, idle}, 32'd0);
    check("t1_addr0", {29'd0, rd_address}, 32'd0);
    check("t1_no_valid_t1", {31'd0, a_valid}, 32'd0);
    @(posedge clk); #1;
    check("t1_avalid_t2", {31'd0, a_valid}, 32'd1);
    check("t1_bvalid_t2", {31'd0, b_valid}, 32'd1);
    check("t1_adata_first", {19'd0, a_data}, 32'd1);
    check("t1_bdata_first", {24'd0, b_data}, 32'h10);
    wait_idle("t1_idle_timeout", cyc);
    check("t1_frame_cycles", cyc, 32'd8);
    check("t1_a_count", n_a - base_a, 32'd8);
    check("t1_queue_empty", qa.size() + qb.size(), 32'd0);

    // b stream stalled: a runs one word ahead, then reads stop.
    base_a = n_a;
    base_b = n_b;
    b_ready = 1'b0;
    start_frame(1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("t2_a_one_ahead", n_a - base_a, 32'd1);
    check("t2_b_none", n_b - base_b, 32'd0);
    check("t2_avalid_low", {31'd0, a_valid}, 32'd0);
    check("t2_bvalid_high", {31'd0, b_valid}, 32'd1);
    stall_addr = rd_address;
    repeat (3) @(posedge clk);
    #1;
    check("t2_addr_stalled", {29'd0, rd_address}, {29'd0, stall_addr});
    check("t2_addr_value", {29'd0, rd_address}, 32'd2);
    b_ready = 1'b1;
    wait_idle("t2_idle_timeout", cyc);
    check("t2_a_count", n_a - base_a, 32'd8);
    check("t2_b_count", n_b - base_b, 32'd8);

    // Index latched at start; input toggles are ignored mid-frame.
    start_frame(1'b1);
    cyc = 0;
    while (idle !== 1'b1 && cyc < 200) begin
      check("t3_index_held", {31'd0, rd_bram_index}, 32'd1);
      if (cyc == 2) bram_index_in = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("t3_idle", {31'd0, idle}, 32'd1);

    // Second start during RUN is ignored.
    base_a = n_a;
    start_frame(1'b1);
    @(posedge clk); #1;
    start = 1'b1;
    bram_index_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("t4_index_kept", {31'd0, rd_bram_index}, 32'd1);
    wait_idle("t4_idle_timeout", cyc);
    check("t4_words", n_a - base_a, 32'd8);
    check("t4_queue_empty", qa.size() + qb.size(), 32'd0);
    start_frame(1'b0);
    check("t4_restart_index", {31'd0, rd_bram_index}, 32'd0);
    wait_idle("t4_restart_timeout", cyc);
    check("t4_words_again", n_a - base_a, 32'd16);

    // Reset after three words aborts the frame at once.
    base_a = n_a;
    start_frame(1'b0);
    cyc = 0;
    while (n_a - base_a < 3 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t5_three_words", n_a - base_a, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("t5_async");
    qa.delete();
    qb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    vbase = n_vcyc;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_valid_after", n_vcyc - vbase, 32'd0);
    check("t5_idle", {31'd0, idle}, 32'd1);
    base_a = n_a;
    start_frame(1'b1);
    wait_idle("t5_after_timeout", cyc);
    check("t5_frame_after", n_a - base_a, 32'd8);
    check("t5_queue_empty", qa.size() + qb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
